// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-axis emulator for joystick port 1.
// PS/2 mouse deltas are scaled, clamped and integrated into saturating signed X/Y axes;
// mouse buttons overlay bits [6:5] of the digital joystick byte while the mouse owns the port.
// Any real stick movement or a CPU halt hands the port back to the real joystick.
// Optional build macro MOUSE_AXIS_SPRING_EN adds a self-centering spring driven by a
// free-running tick counter; without it spring_mode is ignored and the axes hold.
module mouse_axis_emu #(
    parameter int unsigned AXIS_W          = 8,
    parameter int unsigned STEP_MAX        = 10,
    parameter int unsigned SENS_SHIFT      = 0,
    parameter int unsigned RECENTER_PERIOD = 65536
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [24:0]           ps2_mouse,
    input  logic [2*AXIS_W-1:0]   joy_analog,
    input  logic [7:0]            joy_btn,
    input  logic                  halt,
    input  logic                  invert_y,
    input  logic                  spring_mode,
    output logic [2*AXIS_W-1:0]   axis_out,
    output logic [7:0]            btn_out,
    output logic                  emu_active
);

    localparam logic signed [15:0]       StepMaxS = 16'(STEP_MAX);
    localparam logic signed [15:0]       DeltaMax = 16'sd255;
    localparam logic [AXIS_W-1:0]        AccOne   = AXIS_W'(1);
    localparam logic [AXIS_W-1:0]        AccMaxP  = {1'b0, {(AXIS_W-1){1'b1}}};
    localparam logic [AXIS_W-1:0]        AccMaxN  = {1'b1, {(AXIS_W-1){1'b0}}};

    logic                     old_stb_q, old_stb_d;
    logic                     emu_active_q, emu_active_d;
    logic [AXIS_W-1:0]        acc_x_q, acc_x_d;
    logic [AXIS_W-1:0]        acc_y_q, acc_y_d;
    logic                     mouse_evt;
    logic                     clear;
    logic                     tick;

    // Raw 9-bit delta -> optional negation -> arithmetic shift -> symmetric clamp.
    // Worked at 16 bits so the clamp bound never overflows for any legal AXIS_W.
    function automatic logic [AXIS_W:0] form_step(input logic [8:0] raw, input logic neg);
        logic signed [15:0] d;
        logic signed [15:0] s;
        d = {{7{raw[8]}}, raw};
        if (neg) begin
            d = -d;
            if (d > DeltaMax) d = DeltaMax;  // -(-256) would not fit the 9-bit delta range
        end
        s = d >>> SENS_SHIFT;
        if (s > StepMaxS) s = StepMaxS;
        else if (s < -StepMaxS) s = -StepMaxS;
        return s[AXIS_W:0];
    endfunction

    // Add one AXIS_W+1-bit step to an accumulator, saturating on signed overflow.
    function automatic logic [AXIS_W-1:0] sat_add(input logic [AXIS_W-1:0] acc,
                                                  input logic [AXIS_W:0]   step);
        logic [AXIS_W:0] sum;
        sum = {acc[AXIS_W-1], acc} + step;
        if (sum[AXIS_W] != sum[AXIS_W-1]) return sum[AXIS_W] ? AccMaxN : AccMaxP;
        return sum[AXIS_W-1:0];
    endfunction

`ifdef MOUSE_AXIS_SPRING_EN
    localparam int unsigned CntW = $clog2(RECENTER_PERIOD);

    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;

    // One step toward zero; zero stays zero.
    function automatic logic [AXIS_W-1:0] decay(input logic [AXIS_W-1:0] acc);
        if (acc == '0) return acc;
        return acc[AXIS_W-1] ? acc + AccOne : acc - AccOne;
    endfunction

    // Free-running spring counter; tick marks the wrap cycle.
    always_comb begin
        tick       = (tick_cnt_q == CntW'(RECENTER_PERIOD - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);
    end

    // Spring counter register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) tick_cnt_q <= '0;
        else          tick_cnt_q <= tick_cnt_d;
    end
`else
    logic unused_spring;
    assign tick          = 1'b0;
    assign unused_spring = spring_mode ^ (RECENTER_PERIOD == 0);
`endif

    logic unused_ps2;
    assign unused_ps2 = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // Event detect, clear priority, accumulation and optional spring decay.
    always_comb begin
        old_stb_d    = ps2_mouse[24];
        emu_active_d = emu_active_q;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        mouse_evt    = ps2_mouse[24] ^ old_stb_q;
        clear        = (joy_analog != '0) || halt;

        if (clear) begin
            // Real stick or halt wins; a coincident mouse event is discarded.
            emu_active_d = 1'b0;
            acc_x_d      = '0;
            acc_y_d      = '0;
        end else if (mouse_evt) begin
            emu_active_d = 1'b1;
            acc_x_d      = sat_add(acc_x_q, form_step({ps2_mouse[4], ps2_mouse[15:8]}, 1'b0));
            acc_y_d      = sat_add(acc_y_q, form_step({ps2_mouse[5], ps2_mouse[23:16]}, invert_y));
        end
`ifdef MOUSE_AXIS_SPRING_EN
        else if (tick && spring_mode && emu_active_q) begin
            acc_x_d = decay(acc_x_q);
            acc_y_d = decay(acc_y_q);
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_stb_q    <= 1'b0;
            emu_active_q <= 1'b0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
        end else begin
            old_stb_q    <= old_stb_d;
            emu_active_q <= emu_active_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
        end
    end

    // Output muxes; mouse buttons are live, not latched.
    always_comb begin
        emu_active = emu_active_q;
        axis_out   = emu_active_q ? {acc_y_q, acc_x_q} : joy_analog;
        btn_out    = emu_active_q ? {joy_btn[7], ps2_mouse[1:0], joy_btn[4:0]} : joy_btn;
    end

endmodule
